mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port, fixed-latency unified memory between the core's instruction-fetch port and its load/store port, so program and data can sit in one RAM. Grants at most one access per cycle and tracks in-flight reads through a latency-matched tag pipeline. Routes each returning read word back to the port that issued it. Sits between the core datapath and the memory macro; the core stalls while its request is ungranted.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- MEM_LATENCY, 2, cycles from issue to valid mem_rdata (legal range 1..8)
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch issued this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_WIDTH  fetch data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  store byte enables
- d_gnt  out  1  data access issued this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_WIDTH  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en

## Operation
- Arbitration is combinational each cycle: only one requester -> it wins; both -> data wins unless starvation override is active (see Configuration).
- Winner gets gnt=1 and drives mem_en/mem_we/mem_addr/mem_wdata/mem_be the same cycle; loser's gnt=0. No requests -> mem_en=0, all mem_* outputs 0.
- Fetch is always a read: mem_we=0, mem_be all ones.
- Each granted read pushes tag {valid=1, owner} into the tag pipeline; stores and idle cycles push {valid=0}.
- Tag leaving the pipeline with valid=1 raises owner's rvalid for one cycle; rdata = mem_rdata that cycle. Non-owning rdata is 0.
- Stores produce no response; d_gnt is their completion.
- Requesters must not drop or change a request before grant; behaviour under violation is undefined.

## Timing
- Grant latency 0 cycles (same cycle as req, when winning).
- Read issued (gnt) in cycle N -> rvalid in cycle N+MEM_LATENCY, exactly one cycle high.
- Throughput: one access per cycle, back-to-back reads from either or alternating ports fully pipelined; up to MEM_LATENCY reads in flight.
- Issue and return in the same cycle are independent; both ports' rvalid never high together.
- Reset asserted: all gnt, rvalid, rdata, mem_* outputs 0 immediately; tag pipeline and starvation counter cleared; in-flight reads are dropped and never return. Requests are ignored while rst=0 and evaluated from the first edge after release.

## Configuration
- MEM_ARBITER_STARVE_EN defined: a saturating counter increments each cycle if_req=1 and if_gnt=0, clears on if_gnt or when if_req=0. When counter == STARVE_LIMIT, fetch wins the next contention, then counter clears.
- Not defined: strict data priority; no counter; STARVE_LIMIT unused.

## Structure
- Package mem_arbiter_pkg: owner_t enum (OWN_IF, OWN_D), tag_t struct {valid, owner}, MAX_MEM_LATENCY = 8.
- Sub-module arb_tag_pipe: MEM_LATENCY-deep shift register of tag_t, async active-low clear, one push and one pop per cycle.

## Test plan
- Fetch only, if_addr=0x100, MEM_LATENCY=2 -> if_gnt same cycle, mem_addr=0x100, if_rvalid two cycles later carrying mem_rdata.
- Fetch and load both requested cycle N -> d_gnt at N, if_gnt at N+1, d_rvalid at N+2, if_rvalid at N+3, no crossed data.
- Store d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0b0011 -> mem_we=1 with those values, d_gnt=1, no d_rvalid ever.
- With MEM_ARBITER_STARVE_EN, continuous d_req and if_req, STARVE_LIMIT=4 -> if_gnt on the 5th contended cycle; without macro, if_gnt never while d_req=1.
- Reset pulled low one cycle after a read grant -> no rvalid after release; first new read returns correctly.
- Four alternating back-to-back reads with MEM_LATENCY=3 -> four rvalid pulses on consecutive cycles, owners in issue order.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: request owner, in-flight read
// tag, and the deepest memory latency the tag pipeline is sized for.
package mem_arbiter_pkg;

  localparam int MAX_MEM_LATENCY = 8;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  function automatic tag_t make_tag(input logic valid, input owner_t owner);
    tag_t t;
    t.valid = valid;
    t.owner = owner;
    return t;
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Latency-matched tag shift register: one tag enters per cycle, and the one
// leaving marks which port owns the memory word arriving that same cycle.
module arb_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t push,
  output tag_t pop
);

  tag_t [DEPTH-1:0] stage;

  // Async clear drops every in-flight read so none returns after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop = stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter in front of one fixed-latency single-port memory.
// Optional fetch anti-starvation override: define MEM_ARBITER_STARVE_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY || STARVE_LIMIT < 1) begin : g_cfg_check
    $error("mem_arbiter: MEM_LATENCY must be 1..8 and STARVE_LIMIT >= 1");
  end

  logic force_if;
  tag_t push_tag;
  tag_t pop_tag;

`ifdef MEM_ARBITER_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;

  assign force_if = (starve_cnt == CW'(STARVE_LIMIT));

  // Counts consecutive denied fetch cycles; saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (!force_if) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grants are gated by reset so nothing issues while reset is held.
  assign if_gnt = rst && if_req && (!d_req || force_if);
  assign d_gnt  = rst && d_req && !(if_req && force_if);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      mem_be    = '1;
    end
  end

  always_comb begin
    push_tag = make_tag(1'b0, OWN_IF);
    if (d_gnt)       push_tag = make_tag(!d_we, OWN_D);
    else if (if_gnt) push_tag = make_tag(1'b1, OWN_IF);
  end

  arb_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (push_tag),
    .pop  (pop_tag)
  );

  assign if_rvalid = pop_tag.valid && (pop_tag.owner == OWN_IF);
  assign d_rvalid  = pop_tag.valid && (pop_tag.owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 2 and 3) share stimulus; a
// cycle-scheduled response model checks every cycle alongside directed tests.
module tb_mem_arbiter;

  localparam int SL = 4;
`ifdef MEM_ARBITER_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;

  logic [1:0] if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [1:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0][3:0] mem_be;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(SL)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]), .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0]));

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(SL)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]), .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1]));

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  // Memory macro model: word for a read appears exactly latency cycles later.
  logic [1:0][7:0]       hv = '0;
  logic [1:0][7:0][31:0] ha = '0;
  logic [31:0]           junk = 32'h0BAD_F00D;

  always @(posedge clk) begin
    junk <= $urandom;
    for (int k = 0; k < 2; k++) begin
      hv[k] <= {hv[k][6:0], mem_en[k] & ~mem_we[k]};
      ha[k] <= {ha[k][6:0], mem_addr[k]};
    end
  end

  always_comb begin
    mem_rdata[0] = hv[0][1] ? dfun(ha[0][1]) : junk;
    mem_rdata[1] = hv[1][2] ? dfun(ha[1][2]) : junk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: expected responses scheduled by issue cycle + latency.
  logic        sv [2][16];
  logic        so [2][16];
  logic [31:0] sd [2][16];
  int          scnt [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      scnt[k] = 0;
      for (int i = 0; i < 16; i++) begin sv[k][i] = 1'b0; so[k][i] = 1'b0; sd[k][i] = '0; end
    end
  end

  task automatic model_dut(input int k);
    int L, s, t;
    logic e_if, e_d, frc, x_if, x_d;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    L = (k == 0) ? 2 : 3;
    s = cyc % 16;
    if (!rst) begin
      chk("rst_ctl", 32'({if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], mem_en[k], mem_we[k]}), 32'd0);
      chk("rst_bus", if_rdata[k] | d_rdata[k] | mem_addr[k] | mem_wdata[k] | 32'(mem_be[k]), 32'd0);
      for (int i = 0; i < 16; i++) sv[k][i] = 1'b0;
      scnt[k] = 0;
      return;
    end
    frc  = STARVE && (scnt[k] == SL);
    e_if = if_req && (!d_req || frc);
    e_d  = d_req && !e_if;
    chk("if_gnt", 32'(if_gnt[k]), 32'(e_if));
    chk("d_gnt", 32'(d_gnt[k]), 32'(e_d));
    e_addr = e_d ? d_addr : (e_if ? if_addr : 32'd0);
    e_wd   = e_d ? d_wdata : 32'd0;
    e_be   = e_d ? d_be : (e_if ? 4'hF : 4'h0);
    chk("mem_en_we", 32'({mem_en[k], mem_we[k]}), 32'({e_if | e_d, e_d & d_we}));
    chk("mem_addr", mem_addr[k], e_addr);
    chk("mem_wdata", mem_wdata[k], e_wd);
    chk("mem_be", 32'(mem_be[k]), 32'(e_be));
    x_if = sv[k][s] && !so[k][s];
    x_d  = sv[k][s] && so[k][s];
    chk("if_rvalid", 32'(if_rvalid[k]), 32'(x_if));
    chk("d_rvalid", 32'(d_rvalid[k]), 32'(x_d));
    chk("if_rdata", if_rdata[k], x_if ? sd[k][s] : 32'd0);
    chk("d_rdata", d_rdata[k], x_d ? sd[k][s] : 32'd0);
    sv[k][s] = 1'b0;
    if (e_if || (e_d && !d_we)) begin
      t = (cyc + L) % 16;
      sv[k][t] = 1'b1;
      so[k][t] = e_d;
      sd[k][t] = dfun(e_d ? d_addr : if_addr);
    end
    if (if_req && !e_if) scnt[k] = (scnt[k] < SL) ? scnt[k] + 1 : SL;
    else                 scnt[k] = 0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    model_dut(0);
    model_dut(1);
  end

  // Protocol driver step: drop a request once granted, then move to next cycle.
  task automatic tick();
    logic gi, gd;
    gi = if_gnt[0];
    gd = d_gnt[0];
    @(posedge clk);
    #1;
    if (gi) if_req = 1'b0;
    if (gd) begin d_req = 1'b0; d_we = 1'b0; end
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && (if_req || d_req); i++) begin
      @(negedge clk);
      tick();
    end
    if (if_req || d_req) begin
      chk("drain_timeout", 32'd1, 32'd0);
      if_req = 1'b0;
      d_req  = 1'b0;
    end
    d_we = 1'b0;
    repeat (4) begin @(negedge clk); tick(); end
  endtask

  typedef struct {
    logic ir, dr, we;
    logic [31:0] ia, da, wd;
    logic [3:0]  be;
    logic ig, dg, en, mwe;
    logic [31:0] maddr, mwd;
    logic [3:0]  mbe;
  } vec_t;

  vec_t tv [7];

  initial begin
    int first;
    int j;
    tv[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF};
    tv[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h1234, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h1234, 4'hF};
    tv[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h2000, 32'hDEADBEEF, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3};
    tv[4] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF};
    tv[5] = '{1'b1, 1'b1, 1'b1, 32'h30, 32'h40, 32'hCAFEF00D, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hC};
    tv[6] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h55, 32'h77, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF};

    // Reset with requests present: nothing may be granted.
    #1 rst = 1'b0;
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h40; d_addr = 32'h80;
    @(negedge clk);
    chk("rst_ignores_req", 32'({if_gnt, d_gnt, mem_en}), 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if_req = tv[v].ir; d_req = tv[v].dr; d_we = tv[v].we;
      if_addr = tv[v].ia; d_addr = tv[v].da; d_wdata = tv[v].wd; d_be = tv[v].be;
      @(negedge clk);
      chk("tv_if_gnt", 32'(if_gnt[0]), 32'(tv[v].ig));
      chk("tv_d_gnt", 32'(d_gnt[0]), 32'(tv[v].dg));
      chk("tv_mem_en", 32'(mem_en[0]), 32'(tv[v].en));
      chk("tv_mem_we", 32'(mem_we[0]), 32'(tv[v].mwe));
      chk("tv_mem_addr", mem_addr[0], tv[v].maddr);
      chk("tv_mem_wdata", mem_wdata[0], tv[v].mwd);
      chk("tv_mem_be", 32'(mem_be[0]), 32'(tv[v].mbe));
      chk("tv_l3_gnt", 32'({if_gnt[1], d_gnt[1]}), 32'({tv[v].ig, tv[v].dg}));
      tick();
      drain();
    end

    // Fetch-only read, latency 2.
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("t1_if_gnt", 32'(if_gnt[0]), 32'd1);
    chk("t1_mem_addr", mem_addr[0], 32'h100);
    tick();
    @(negedge clk);
    chk("t1_rvalid_early", 32'(if_rvalid[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_if_rvalid", 32'(if_rvalid[0]), 32'd1);
    chk("t1_if_rdata", if_rdata[0], dfun(32'h100));
    tick();
    @(negedge clk);
    chk("t1_rvalid_one_cycle", 32'(if_rvalid[0]), 32'd0);
    tick();
    drain();

    // Contention: data first, fetch next cycle, responses not crossed.
    if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    @(negedge clk);
    chk("t2_gnt_n", 32'({if_gnt[0], d_gnt[0]}), 32'b01);
    tick();
    @(negedge clk);
    chk("t2_gnt_n1", 32'({if_gnt[0], d_gnt[0]}), 32'b10);
    tick();
    @(negedge clk);
    chk("t2_rvalid_n2", 32'({if_rvalid[0], d_rvalid[0]}), 32'b01);
    chk("t2_d_rdata", d_rdata[0], dfun(32'h400));
    chk("t2_if_rdata_zero", if_rdata[0], 32'd0);
    tick();
    @(negedge clk);
    chk("t2_rvalid_n3", 32'({if_rvalid[0], d_rvalid[0]}), 32'b10);
    chk("t2_if_rdata", if_rdata[0], dfun(32'h300));
    chk("t2_d_rdata_zero", d_rdata[0], 32'd0);
    tick();
    drain();

    // Store: write strobes out, never a response.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    @(negedge clk);
    chk("t3_store_bus", 32'({d_gnt[0], mem_en[0], mem_we[0], mem_be[0]}), 32'b1110011);
    chk("t3_store_addr", mem_addr[0], 32'h2000);
    chk("t3_store_data", mem_wdata[0], 32'hDEADBEEF);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_no_d_rvalid", 32'({d_rvalid[0], d_rvalid[1]}), 32'd0);
      tick();
    end

    // Continuous contention: fetch wins only through the starvation override.
    first = 0;
    if_req = 1'b1; if_addr = 32'h500;
    for (int i = 1; i <= 8; i++) begin
      if (first == 0) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600 + 32'(i * 4);
        @(negedge clk);
        if (if_gnt[0]) first = i;
        tick();
      end
    end
    chk("t4_first_if_gnt", 32'(first), STARVE ? 32'd5 : 32'd0);
    drain();

    // Reset one cycle after a read grant drops the read.
    if_req = 1'b1; if_addr = 32'h700;
    @(negedge clk);
    chk("t5_gnt", 32'(if_gnt[0]), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_in_reset", 32'({if_rvalid, d_rvalid, mem_en}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_stale_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
      tick();
    end
    if_req = 1'b1; if_addr = 32'h704;
    @(negedge clk); tick();
    @(negedge clk); tick();
    @(negedge clk);
    chk("t5_new_read", 32'(if_rvalid[0]), 32'd1);
    chk("t5_new_rdata", if_rdata[0], dfun(32'h704));
    tick();
    drain();

    // Alternating back-to-back reads on the latency-3 instance.
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        if (i % 2 == 0) begin if_req = 1'b1; if_addr = 32'h800 + 32'(4 * i); end
        else begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800 + 32'(4 * i); end
      end
      @(negedge clk);
      if (i >= 3) begin
        j = i - 3;
        chk("t6_owner", 32'({if_rvalid[1], d_rvalid[1]}), (j % 2 == 0) ? 32'b10 : 32'b01);
        chk("t6_rdata", (j % 2 == 0) ? if_rdata[1] : d_rdata[1], dfun(32'h800 + 32'(4 * j)));
      end
      tick();
    end
    drain();

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      if (!if_req && $urandom_range(0, 99) < 60) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 99) < 60) begin
        d_req = 1'b1; d_we = ($urandom_range(0, 2) == 0);
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      end
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      @(negedge clk);
      tick();
    end
    rst = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
